// File: rtl/prog_loader.sv
// Program loader: streams a 16-byte program plus checksum into a register array
// and gates the CPU clock enable, with idle timeout and checksum error reporting.
module prog_loader #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic       clk_cpu,
   input  logic       reset,
   input  logic       load_req,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   input  logic [3:0] cpu_adrs,
   output logic [7:0] cpu_dat,
   output logic       cpu_run,
   output logic       cpu_restart,
   output logic       load_done,
   output logic [1:0] err
);

   localparam int unsigned IdleW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   localparam logic [2:0] StEmpty = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StCksum = 3'd2;
   localparam logic [2:0] StRun   = 3'd3;
   localparam logic [2:0] StError = 3'd4;

   localparam logic [1:0] ErrNone    = 2'b00;
   localparam logic [1:0] ErrCksum   = 2'b01;
   localparam logic [1:0] ErrTimeout = 2'b10;

   logic [2:0]       state_q, state_d;
   logic [7:0]       mem_q [16];
   logic [3:0]       idx_q, idx_d;
   logic [7:0]       sum_q, sum_d;
   logic [IdleW-1:0] idle_q, idle_d;
   logic [1:0]       err_q, err_d;
   logic             pulse_q, pulse_d;
   logic             mem_we;
   logic             accept;
   logic             idle_expired;
   logic [7:0]       sum_next;

   assign byte_ready   = (state_q == StLoad) || (state_q == StCksum);
   assign accept       = byte_valid && byte_ready;
   assign sum_next     = sum_q + byte_data;
   // The cycle that would be idle cycle number TIMEOUT trips the timeout unless a byte lands.
   assign idle_expired = (idle_q == IdleW'(TIMEOUT - 1));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      sum_d   = sum_q;
      idle_d  = idle_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      case (state_q)
         StEmpty, StRun, StError: begin
            if (load_req) begin
               state_d = StLoad;
               idx_d   = 4'd0;
               sum_d   = 8'd0;
               idle_d  = '0;
               err_d   = ErrNone;
            end
         end
         StLoad: begin
            if (accept) begin
               mem_we = 1'b1;
               sum_d  = sum_next;
               idle_d = '0;
               if (idx_q == 4'd15) begin
                  state_d = StCksum;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else if (idle_expired) begin
               state_d = StError;
               err_d   = ErrTimeout;
            end else begin
               idle_d = idle_q + IdleW'(1);
            end
         end
         StCksum: begin
            if (accept) begin
               idle_d = '0;
               if (sum_next == 8'h00) begin
                  state_d = StRun;
               end else begin
                  state_d = StError;
                  err_d   = ErrCksum;
               end
            end else if (idle_expired) begin
               state_d = StError;
               err_d   = ErrTimeout;
            end else begin
               idle_d = idle_q + IdleW'(1);
            end
         end
         default: state_d = StEmpty;
      endcase
      pulse_d = (state_q == StCksum) && (state_d == StRun);
   end

   always_ff @(posedge clk_cpu) begin
      if (!reset) begin
         state_q <= StEmpty;
         idx_q   <= 4'd0;
         sum_q   <= 8'd0;
         idle_q  <= '0;
         err_q   <= ErrNone;
         pulse_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         sum_q   <= sum_d;
         idle_q  <= idle_d;
         err_q   <= err_d;
         pulse_q <= pulse_d;
      end
   end

   always_ff @(posedge clk_cpu) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            mem_q[i] <= 8'h00;
         end
      end else if (mem_we) begin
         mem_q[idx_q] <= byte_data;
      end
   end

   assign cpu_run     = (state_q == StRun);
   assign cpu_dat     = cpu_run ? mem_q[cpu_adrs] : 8'h00;
   assign load_done   = pulse_q;
   assign cpu_restart = pulse_q;
   assign err         = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomized and directed bench for prog_loader; expected outcomes come from the
// byte stream, gap lengths and checksum arithmetic held in the bench.
module tb_prog_loader;

   localparam int TO = 4;

   logic       clk_cpu = 1'b0;
   logic       reset;
   logic       load_req;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;
   logic [3:0] cpu_adrs;
   logic [7:0] cpu_dat;
   logic       cpu_run;
   logic       cpu_restart;
   logic       load_done;
   logic [1:0] err;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0] exp_mem  [16];
   logic [7:0] stim_data[17];
   int         stim_gap [17];

   prog_loader #(.TIMEOUT(TO)) dut (
      .clk_cpu    (clk_cpu),
      .reset      (reset),
      .load_req   (load_req),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .cpu_adrs   (cpu_adrs),
      .cpu_dat    (cpu_dat),
      .cpu_run    (cpu_run),
      .cpu_restart(cpu_restart),
      .load_done  (load_done),
      .err        (err)
   );

   always #20 clk_cpu = ~clk_cpu;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk_cpu);
      #1;
   endtask

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag, input logic [1:0] exp_err);
      check_eq({tag, "_ready"}, 32'(byte_ready), 32'(0));
      check_eq({tag, "_run"}, 32'(cpu_run), 32'(0));
      check_eq({tag, "_done"}, 32'(load_done), 32'(0));
      check_eq({tag, "_restart"}, 32'(cpu_restart), 32'(0));
      check_eq({tag, "_err"}, 32'(err), 32'(exp_err));
      check_eq({tag, "_dat"}, 32'(cpu_dat), 32'(0));
   endtask

   task automatic set_stream(input logic [7:0] base, input logic [7:0] cks);
      for (int i = 0; i < 16; i++) begin
         stim_data[i] = base + 8'(i);
         stim_gap[i]  = 0;
      end
      stim_data[16] = cks;
      stim_gap[16]  = 0;
   endtask

   // Plays the stream in stim_data/stim_gap and checks the outcome implied by the gaps
   // (a run of TO idle cycles times out) and by the mod-256 checksum.
   task automatic run_load(input bit hold_req);
      bit         timed_out = 1'b0;
      int         accepts   = 0;
      int         sent      = 0;
      logic [7:0] s         = 8'h00;
      load_req = 1'b1;
      tick();
      if (!hold_req) load_req = 1'b0;
      check_eq("enter_ready", 32'(byte_ready), 32'(1));
      check_eq("enter_run", 32'(cpu_run), 32'(0));
      check_eq("enter_err", 32'(err), 32'(0));
      for (int i = 0; i < 17 && !timed_out; i++) begin
         for (int g = 0; g < stim_gap[i] && !timed_out; g++) begin
            byte_valid = 1'b0;
            tick();
            if (g == TO - 1) begin
               timed_out = 1'b1;
               check_eq("timeout_err", 32'(err), 32'(2));
               check_eq("timeout_ready", 32'(byte_ready), 32'(0));
               check_eq("timeout_run", 32'(cpu_run), 32'(0));
            end else begin
               check_eq("idle_ready", 32'(byte_ready), 32'(1));
               check_eq("idle_err", 32'(err), 32'(0));
            end
         end
         if (!timed_out) begin
            byte_valid = 1'b1;
            byte_data  = stim_data[i];
            if (byte_ready) accepts++;
            tick();
            byte_valid = 1'b0;
            sent++;
            s = s + stim_data[i];
            if (i < 16) begin
               exp_mem[i] = stim_data[i];
               check_eq("load_run", 32'(cpu_run), 32'(0));
               check_eq("load_done_early", 32'(load_done), 32'(0));
            end
         end
      end
      load_req = 1'b0;
      check_eq("accepts", 32'(accepts), 32'(sent));
      if (!timed_out) begin
         if (s == 8'h00) begin
            check_eq("done_pulse", 32'(load_done), 32'(1));
            check_eq("restart_pulse", 32'(cpu_restart), 32'(1));
            check_eq("run_first", 32'(cpu_run), 32'(1));
            check_eq("run_err", 32'(err), 32'(0));
            tick();
            check_eq("done_single", 32'(load_done), 32'(0));
            check_eq("restart_single", 32'(cpu_restart), 32'(0));
            check_eq("run_hold", 32'(cpu_run), 32'(1));
            check_eq("run_ready", 32'(byte_ready), 32'(0));
            for (int a = 0; a < 16; a++) begin
               cpu_adrs = 4'(a);
               #1;
               check_eq("mem_read", 32'(cpu_dat), 32'(exp_mem[a]));
            end
         end else begin
            cpu_adrs = 4'hA;
            #1;
            check_idle_outputs("cksum_fail", 2'b01);
         end
      end
   endtask

   initial begin
      reset      = 1'b0;
      load_req   = 1'b0;
      byte_valid = 1'b0;
      byte_data  = 8'h00;
      cpu_adrs   = 4'h0;
      for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
      tick();
      tick();
      check_idle_outputs("reset", 2'b00);
      reset = 1'b1;
      tick();
      tick();
      check_eq("empty_stays", 32'(byte_ready), 32'(0));

      // Good load, then a bad checksum.
      set_stream(8'h00, 8'h88);
      run_load(1'b0);
      set_stream(8'h00, 8'h87);
      run_load(1'b0);

      // Timeout after the 3rd byte, then a byte landing on the last allowed idle cycle.
      set_stream(8'h00, 8'h88);
      stim_gap[3] = TO;
      run_load(1'b0);
      set_stream(8'h00, 8'h88);
      stim_gap[3] = TO - 1;
      run_load(1'b0);

      // load_req held through the load with valid every other cycle.
      set_stream(8'h00, 8'h88);
      for (int i = 0; i < 17; i++) stim_gap[i] = 1;
      run_load(1'b1);
      byte_valid = 1'b1;
      tick();
      byte_valid = 1'b0;
      check_eq("run_no_accept", 32'(load_done), 32'(0));

      // Reset mid-load abandons it with no pulses; mem returns to zero.
      load_req = 1'b1;
      tick();
      load_req = 1'b0;
      for (int i = 0; i < 8; i++) begin
         byte_valid = 1'b1;
         byte_data  = 8'h55;
         tick();
      end
      byte_valid = 1'b0;
      reset = 1'b0;
      tick();
      check_idle_outputs("mid_reset", 2'b00);
      reset = 1'b1;
      for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;
      tick();
      check_idle_outputs("post_reset", 2'b00);
      set_stream(8'h00, 8'h88);
      run_load(1'b0);

      // Reload from RUN.
      set_stream(8'hF0, 8'h88);
      run_load(1'b0);
      cpu_adrs = 4'h3;
      #1;
      check_eq("reload_f3", 32'(cpu_dat), 32'(8'hF3));

      for (int n = 0; n < 24; n++) begin
         logic [7:0] s = 8'h00;
         for (int i = 0; i < 16; i++) begin
            stim_data[i] = 8'($urandom);
            s = s + stim_data[i];
         end
         stim_data[16] = ($urandom_range(0, 3) != 0) ? 8'(8'h00 - s) : 8'($urandom);
         for (int i = 0; i < 17; i++) begin
            stim_gap[i] = ($urandom_range(0, 24) == 0) ? $urandom_range(TO, TO + 1)
                                                       : $urandom_range(0, TO - 1);
         end
         run_load($urandom_range(0, 1) == 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
